jt1943_rom_responder: RTL and testbench

JT1943_ROM_RESPONDER -- requirements
Module: jt1943_rom_responder

---
 rtl/jt1943_rom_responder_if.sv | 42 ++++
 rtl/jt1943_rom_responder.sv | 168 ++++++++++++++++
 tb/tb_jt1943_rom_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt1943_rom_responder_if.sv
// ---------------------------------------------------------------------------
// jt1943_rom_responder_if
// Bundle of the client-side and memory-side signals of the ROM responder.
//   cen            client clock enable (clients sample we only when cen=1)
//   req0/req1      client read requests (level)
//   addr0/addr1    client byte addresses, bits [1:0] unused
//   we0/we1        data-valid strobes back to each client
//   dout           fetched 32-bit word, shared by both clients
//   mem_rd         memory read request, held until acknowledged
//   mem_addr       16-bit-word address to memory
//   mem_ack        one-cycle acknowledge, mem_data valid with it
//   mem_data       16-bit memory read data
//   busy           responder is not idle
// slave modport: the responder. master modport: the clients plus memory.
// ---------------------------------------------------------------------------
interface jt1943_rom_responder_if #(
  parameter int AW = 18
);
  logic          cen;
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          we0;
  logic          we1;
  logic [31:0]   dout;
  logic          mem_rd;
  logic [AW-2:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;
  logic          busy;

  modport slave (
    input  cen, req0, req1, addr0, addr1, mem_ack, mem_data,
    output we0, we1, dout, mem_rd, mem_addr, busy
  );

  modport master (
    output cen, req0, req1, addr0, addr1, mem_ack, mem_data,
    input  we0, we1, dout, mem_rd, mem_addr, busy
  );
endinterface

// File: rtl/jt1943_rom_responder.sv
// ---------------------------------------------------------------------------
// jt1943_rom_responder
// Serves 32-bit ROM reads for two clients from a 16-bit memory. A request is
// granted round-robin, the word is fetched as two 16-bit halves (low half
// first), then presented on dout with the granted client's we strobe until
// the client consumes it on a cen-qualified edge.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   jt1943_rom_responder_if.slave (client and memory signals)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module jt1943_rom_responder #(
  parameter int AW = 18
) (
  input logic                    clk,
  input logic                    rst,
  jt1943_rom_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LO   = 2'd1,
    RD_HI   = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t        state_r,    state_s;
  logic [AW-2:0] mem_addr_r, mem_addr_s;
  logic          mem_rd_r,   mem_rd_s;
  logic [31:0]   dout_r,     dout_s;
  logic          we0_r,      we0_s;
  logic          we1_r,      we1_s;
  logic          busy_r,     busy_s;
  // ptr: port preferred on the next contended grant (0 = port 0)
  logic          ptr_r,      ptr_s;
  // port: port owning the fetch in flight
  logic          port_r,     port_s;
  logic          grant_s;
  logic [AW-3:0] addr_sel_s;

  // Byte-lane bits of the client addresses play no part in a word fetch.
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^{bus.addr0[1:0], bus.addr1[1:0]};

  // Next-state and next-output logic of the fetch sequencer.
  always_comb begin
    state_s    = state_r;
    mem_addr_s = mem_addr_r;
    mem_rd_s   = mem_rd_r;
    dout_s     = dout_r;
    we0_s      = we0_r;
    we1_s      = we1_r;
    ptr_s      = ptr_r;
    port_s     = port_r;
    grant_s    = 1'b0;
    addr_sel_s = bus.addr0[AW-1:2];

    case (state_r)
      IDLE: begin
        // A lone requester wins outright; the pointer only settles contention.
        if (bus.req0 && bus.req1) begin
          grant_s = ptr_r;
        end else if (bus.req1) begin
          grant_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end

        if (grant_s) begin
          addr_sel_s = bus.addr1[AW-1:2];
        end else begin
          addr_sel_s = bus.addr0[AW-1:2];
        end

        if (bus.req0 || bus.req1) begin
          port_s     = grant_s;
          mem_addr_s = {addr_sel_s, 1'b0};
          mem_rd_s   = 1'b1;
          state_s    = RD_LO;
        end else begin
          mem_rd_s   = 1'b0;
          we0_s      = 1'b0;
          we1_s      = 1'b0;
          state_s    = IDLE;
        end
      end

      RD_LO: begin
        if (bus.mem_ack) begin
          dout_s[15:0]  = bus.mem_data;
          mem_addr_s[0] = 1'b1;
          state_s       = RD_HI;
        end else begin
          state_s       = RD_LO;
        end
      end

      RD_HI: begin
        // Strobe is raised together with the last half so it lines up with
        // the complete word on dout.
        if (bus.mem_ack) begin
          dout_s[31:16] = bus.mem_data;
          mem_rd_s      = 1'b0;
          we0_s         = ~port_r;
          we1_s         = port_r;
          state_s       = DELIVER;
        end else begin
          state_s       = RD_HI;
        end
      end

      DELIVER: begin
        // The client has taken the word once it sees we on a cen edge.
        if (bus.cen) begin
          we0_s   = 1'b0;
          we1_s   = 1'b0;
          ptr_s   = ~port_r;
          state_s = IDLE;
        end else begin
          state_s = DELIVER;
        end
      end

      default: begin
        mem_rd_s = 1'b0;
        we0_s    = 1'b0;
        we1_s    = 1'b0;
        state_s  = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mem_addr_r <= '0;
      mem_rd_r   <= 1'b0;
      dout_r     <= 32'h0000_0000;
      we0_r      <= 1'b0;
      we1_r      <= 1'b0;
      busy_r     <= 1'b0;
      ptr_r      <= 1'b0;
      port_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      mem_addr_r <= mem_addr_s;
      mem_rd_r   <= mem_rd_s;
      dout_r     <= dout_s;
      we0_r      <= we0_s;
      we1_r      <= we1_s;
      busy_r     <= busy_s;
      ptr_r      <= ptr_s;
      port_r     <= port_s;
    end
  end

  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.dout     = dout_r;
  assign bus.we0      = we0_r;
  assign bus.we1      = we1_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_jt1943_rom_responder.sv
// ---------------------------------------------------------------------------
// tb_jt1943_rom_responder
// Self-checking bench for jt1943_rom_responder. A memory model answers reads
// with a configurable delay, a monitor records every word a client consumes,
// and each test task compares against a reference of the arbitration and
// fetch rules kept in the bench.
// ---------------------------------------------------------------------------
module tb_jt1943_rom_responder;
  localparam int AW = 18;
  localparam int WA = AW - 1;

  logic clk = 1'b0;
  logic rst;

  jt1943_rom_responder_if #(.AW(AW)) bus ();

  jt1943_rom_responder #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  int          cen_mode = 0;
  bit          force_ack = 1'b0;
  logic [15:0] salt;
  bit          model_ptr = 1'b0;
  int          dq_port[$];
  logic [31:0] dq_word[$];
  int          we_hi_cnt[2];
  int          we_cen_cnt[2];

  // Memory contents: two fixed words plus a salted hash everywhere else.
  function automatic logic [15:0] mem_word(input logic [WA-1:0] wa);
    logic [31:0] h;
    if (wa == WA'(17'h00082)) return 16'hBEEF;
    else if (wa == WA'(17'h00083)) return 16'hDEAD;
    else begin
      h = 32'(wa) * 32'h9E37_79B1;
      return h[31:16] ^ salt;
    end
  endfunction

  // 32-bit word the client at byte address a must receive.
  function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
    logic [WA-1:0] wlo;
    wlo = WA'((32'(a) >> 2) << 1);
    return {mem_word(wlo + WA'(1)), mem_word(wlo)};
  endfunction

  function automatic logic [WA-1:0] exp_lo_addr(input logic [AW-1:0] a);
    return WA'((32'(a) >> 2) << 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives cen and plays the memory.
  task automatic env_loop();
    int cyc;
    int wait_cnt;
    cyc = 0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (cen_mode)
        0:       bus.cen = 1'b1;
        1:       bus.cen = ((cyc % 4) == 0);
        default: bus.cen = 1'($urandom_range(0, 1));
      endcase
      bus.mem_ack = 1'b0;
      if (force_ack) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = 16'hA5A5;
      end else if (bus.mem_rd && !rst) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mem_word(bus.mem_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  endtask

  // Records every consumed word and checks strobe exclusivity and release.
  task automatic monitor_loop();
    bit exit_pending;
    exit_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exit_pending = 1'b0;
      end else begin
        if (exit_pending) begin
          n_cmp++;
          if (bus.we0 || bus.we1) begin
            n_err++;
            $display("FAIL we_release: we0=%0b we1=%0b after consuming edge, required 0", bus.we0, bus.we1);
          end
          exit_pending = 1'b0;
        end
        if (bus.we0 || bus.we1) begin
          n_cmp++;
          if (bus.we0 && bus.we1) begin
            n_err++;
            $display("FAIL we_exclusive: we0=1 we1=1, required one strobe only");
          end
          if (bus.we0) we_hi_cnt[0]++;
          else we_hi_cnt[1]++;
          if (bus.cen) begin
            dq_port.push_back(bus.we1 ? 1 : 0);
            dq_word.push_back(bus.dout);
            if (bus.we0) we_cen_cnt[0]++;
            else we_cen_cnt[1]++;
            exit_pending = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 6 && bus.busy !== 1'b1; i++) tick();
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_grant: busy=%0b, required 1 within budget", name, bus.busy);
    end
  endtask

  task automatic wait_deliv(input int n, input int bound, input string name);
    for (int i = 0; i < bound && dq_port.size() < n; i++) tick();
    n_cmp++;
    if (dq_port.size() < n) begin
      n_err++;
      $display("FAIL %s_timeout: deliveries=%0d, required %0d", name, dq_port.size(), n);
    end
  endtask

  task automatic check_deliv(input int idx, input int port, input logic [31:0] word, input string name);
    n_cmp++;
    if (idx >= dq_port.size()) begin
      n_err++;
      $display("FAIL %s_missing: delivery %0d absent", name, idx);
    end else if (dq_port[idx] != port || dq_word[idx] !== word) begin
      n_err++;
      $display("FAIL %s: port=%0d word=%h, required port=%0d word=%h", name, dq_port[idx], dq_word[idx], port, word);
    end
  endtask

  task automatic test_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    do_reset();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd: got %0b want 0", bus.mem_rd); end
    n_cmp++; if (bus.mem_addr !== WA'(0)) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.we0 !== 1'b0 || bus.we1 !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b%0b want 00", bus.we0, bus.we1); end
    n_cmp++; if (bus.dout !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
  endtask

  // Zero-wait single fetch with exact cycle-by-cycle expectations.
  task automatic test_single();
    cen_mode = 0;
    ack_delay = 0;
    bus.addr0 = 18'h00104;
    bus.req0 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 17'h00082) begin n_err++; $display("FAIL single_lo: rd=%0b addr=%h want rd=1 addr=00082", bus.mem_rd, bus.mem_addr); end
    tick();
    n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 17'h00083) begin n_err++; $display("FAIL single_hi: rd=%0b addr=%h want rd=1 addr=00083", bus.mem_rd, bus.mem_addr); end
    tick();
    n_cmp++; if (bus.we0 !== 1'b1 || bus.we1 !== 1'b0 || bus.dout !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_deliver: we=%0b%0b dout=%h want we0=1 we1=0 dout=deadbeef", bus.we0, bus.we1, bus.dout); end
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL single_rd_drop: got %0b want 0", bus.mem_rd); end
    tick();
    n_cmp++; if (bus.we0 !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_turnaround: we0=%0b busy=%0b want 0 0", bus.we0, bus.busy); end
    model_ptr = 1'b1;
  endtask

  // Both clients hold requests: grants must alternate starting at port 0.
  task automatic test_round_robin();
    logic [AW-1:0] a0, a1;
    int base;
    do_reset();
    a0 = AW'($urandom());
    a1 = AW'($urandom());
    bus.addr0 = a0;
    bus.addr1 = a1;
    ack_delay = 1;
    base = dq_port.size();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_deliv(base + 6, 200, "rr");
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_deliv(base + i, int'(model_ptr), model_ptr ? exp_word(a1) : exp_word(a0), "rr_order");
      model_ptr = ~model_ptr;
    end
    tick();
  endtask

  // Slow cen during delivery; a stray ack in DELIVER must not touch dout.
  task automatic test_cen_deliver();
    logic [AW-1:0] a0;
    int base, hi0, cen0;
    cen_mode = 1;
    ack_delay = 0;
    a0 = AW'($urandom());
    bus.addr0 = a0;
    base = dq_port.size();
    hi0 = we_hi_cnt[0];
    cen0 = we_cen_cnt[0];
    bus.req0 = 1'b1;
    wait_busy("cen");
    bus.req0 = 1'b0;
    for (int i = 0; i < 20 && bus.we0 !== 1'b1; i++) tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    wait_deliv(base + 1, 40, "cen");
    tick();
    tick();
    check_deliv(base, 0, exp_word(a0), "cen_word");
    n_cmp++; if (we_cen_cnt[0] - cen0 != 1) begin n_err++; $display("FAIL cen_qualified: got %0d cen edges want 1", we_cen_cnt[0] - cen0); end
    n_cmp++; if (we_hi_cnt[0] - hi0 < 1 || we_hi_cnt[0] - hi0 > 4) begin n_err++; $display("FAIL cen_we_width: got %0d cycles want 1..4", we_hi_cnt[0] - hi0); end
    n_cmp++; if (bus.dout !== exp_word(a0)) begin n_err++; $display("FAIL cen_dout_hold: got %h want %h", bus.dout, exp_word(a0)); end
    model_ptr = 1'b1;
    cen_mode = 0;
  endtask

  // Slow memory; requester drops and changes address during the high half.
  task automatic test_hold_addr();
    logic [AW-1:0] a1;
    logic [WA-1:0] lo;
    int base;
    cen_mode = 0;
    ack_delay = 5;
    a1 = AW'($urandom());
    lo = exp_lo_addr(a1);
    bus.addr1 = a1;
    base = dq_port.size();
    bus.req1 = 1'b1;
    wait_busy("hold");
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== lo) begin
        n_err++;
        $display("FAIL hold_wait: rd=%0b addr=%h want rd=1 addr=%h", bus.mem_rd, bus.mem_addr, lo);
      end
      tick();
    end
    for (int i = 0; i < 20 && bus.mem_addr !== (lo | WA'(1)); i++) tick();
    tick();
    bus.req1 = 1'b0;
    bus.addr1 = ~a1;
    wait_deliv(base + 1, 60, "hold");
    check_deliv(base, 1, exp_word(a1), "hold_word");
    model_ptr = 1'b0;
    tick();
  endtask

  // Reset in the middle of the high half, then a stray acknowledge.
  task automatic test_reset_mid();
    logic [AW-1:0] a0;
    int base;
    ack_delay = 5;
    a0 = AW'($urandom());
    bus.addr0 = a0;
    bus.req0 = 1'b1;
    wait_busy("rstmid");
    bus.req0 = 1'b0;
    for (int i = 0; i < 20 && bus.mem_addr !== (exp_lo_addr(a0) | WA'(1)); i++) tick();
    base = dq_port.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: busy=%0b rd=%0b want 0 0", bus.busy, bus.mem_rd); end
    n_cmp++; if (bus.dout !== 32'h0 || bus.mem_addr !== WA'(0)) begin n_err++; $display("FAIL rstmid_clear: dout=%h addr=%h want 0 0", bus.dout, bus.mem_addr); end
    for (int i = 0; i < 12; i++) tick();
    n_cmp++; if (dq_port.size() != base || bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_no_deliver: deliveries=%0d busy=%0b want %0d 0", dq_port.size(), bus.busy, base); end
    model_ptr = 1'b0;
  endtask

  // Random request mixes, addresses, memory latency and cen.
  task automatic test_random();
    logic [AW-1:0] a0, a1;
    int pat, base, g;
    cen_mode = 2;
    for (int t = 0; t < 24; t++) begin
      ack_delay = $urandom_range(0, 3);
      pat = $urandom_range(1, 3);
      a0 = AW'($urandom());
      a1 = AW'($urandom());
      bus.addr0 = a0;
      bus.addr1 = a1;
      base = dq_port.size();
      bus.req0 = pat[0];
      bus.req1 = pat[1];
      if (pat == 3) g = int'(model_ptr);
      else g = (pat == 2) ? 1 : 0;
      wait_busy("rand");
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.addr0 = AW'($urandom());
      bus.addr1 = AW'($urandom());
      wait_deliv(base + 1, 100, "rand");
      check_deliv(base, g, (g == 1) ? exp_word(a1) : exp_word(a0), "rand_word");
      model_ptr = (g == 0);
      for (int i = 0; i < 10 && bus.busy !== 1'b0; i++) tick();
    end
    cen_mode = 0;
  endtask

  initial begin
    salt = 16'($urandom());
    rst = 1'b1;
    bus.cen = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.mem_ack = 1'b0;
    bus.mem_data = 16'h0000;
    we_hi_cnt[0] = 0;
    we_hi_cnt[1] = 0;
    we_cen_cnt[0] = 0;
    we_cen_cnt[1] = 0;
    fork
      env_loop();
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_cen_deliver();
    test_hold_addr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
